// File: rtl/bins_to_registered_clocks.sv
// Stimulus encoder for the photon binner: turns (bin, count, gap) commands into
// registered detection-line pulses plus the byte the binner should report for each.
module bins_to_registered_clocks #(
  parameter int COUNT_W = 16,
  parameter int GAP_W   = 8
) (
  input  logic               clkin,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_bin,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic [GAP_W-1:0]   cmd_gap,
  input  logic               abort,
  output logic               photonFirstHalf,
  output logic               photonSecondHalf,
  output logic               photon2x,
  output logic               photon4x,
  output logic [7:0]         exp_data,
  output logic               exp_valid,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] pulse_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]         r_state;
  logic [2:0]         r_bin;
  logic [COUNT_W-1:0] r_count;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   r_gap_cnt;

  logic [1:0] w_next_state;
  logic       w_accept;
  logic       w_last;
  logic [2:0] w_emit_bin;

  // Line order {first half, second half, even quarter, even eighth}.
  function automatic logic [3:0] f_encode(input logic [2:0] b);
    return {~b[2], b[2], ~b[1], ~b[0]};
  endfunction

  assign w_accept   = cmd_valid & (r_state == ST_IDLE);
  assign w_last     = (({1'b0, pulse_cnt} + (COUNT_W + 1)'(1)) == {1'b0, r_count});
  assign w_emit_bin = w_accept ? cmd_bin : r_bin;

  // Next-state decode; outputs are registered from the state being entered.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (cmd_count != '0)) w_next_state = ST_EMIT;
        else                               w_next_state = ST_IDLE;
      end
      ST_EMIT: begin
        if (abort || w_last)       w_next_state = ST_IDLE;
        else if (r_gap == '0)      w_next_state = ST_EMIT;
        else                       w_next_state = ST_GAP;
      end
      ST_GAP: begin
        if (abort)                           w_next_state = ST_IDLE;
        else if (r_gap_cnt == GAP_W'(1))     w_next_state = ST_EMIT;
        else                                 w_next_state = ST_GAP;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Burst sequencing and all registered outputs.
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      r_state          <= ST_IDLE;
      r_bin            <= 3'd0;
      r_count          <= '0;
      r_gap            <= '0;
      r_gap_cnt        <= '0;
      cmd_ready        <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      pulse_cnt        <= '0;
      photonFirstHalf  <= 1'b0;
      photonSecondHalf <= 1'b0;
      photon2x         <= 1'b0;
      photon4x         <= 1'b0;
      exp_data         <= 8'd0;
      exp_valid        <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      cmd_ready <= (w_next_state == ST_IDLE);
      busy      <= (w_next_state != ST_IDLE);

      if (w_accept) begin
        r_bin     <= cmd_bin;
        r_count   <= cmd_count;
        r_gap     <= cmd_gap;
        pulse_cnt <= '0;
      end else if (r_state == ST_EMIT) begin
        pulse_cnt <= pulse_cnt + COUNT_W'(1);
      end else begin
        pulse_cnt <= pulse_cnt;
      end

      if (r_state == ST_EMIT)     r_gap_cnt <= r_gap;
      else if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      else                        r_gap_cnt <= r_gap_cnt;

      if (w_next_state == ST_EMIT)
        {photonFirstHalf, photonSecondHalf, photon2x, photon4x} <= f_encode(w_emit_bin);
      else
        {photonFirstHalf, photonSecondHalf, photon2x, photon4x} <= 4'b0000;

      // The pulse of an aborted final EMIT cycle still gets its expected byte.
      exp_valid <= (r_state == ST_EMIT);
      exp_data  <= (r_state == ST_EMIT) ? (8'd1 << r_bin) : 8'd0;

      done <= (w_accept && (cmd_count == '0)) ||
              ((r_state == ST_EMIT) && w_last && !abort);
    end
  end

endmodule

// File: tb/tb_bins_to_registered_clocks.sv
// Scoreboard bench: a slot-level event model predicts pulses, expected bytes and
// done strobes; a monitor compares every cycle, plus a behavioural binner cross-check.
module tb_bins_to_registered_clocks;
  localparam int CW = 16;
  localparam int GW = 8;

  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic          rstn, cmd_valid, abort;
  logic [2:0]    cmd_bin;
  logic [CW-1:0] cmd_count;
  logic [GW-1:0] cmd_gap;
  logic          cmd_ready, photonFirstHalf, photonSecondHalf, photon2x, photon4x;
  logic [7:0]    exp_data;
  logic          exp_valid, busy, done;
  logic [CW-1:0] pulse_cnt;
  logic [7:0]    bin_data;

  bins_to_registered_clocks #(.COUNT_W(CW), .GAP_W(GW)) dut (
    .clkin(clkin), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_bin(cmd_bin), .cmd_count(cmd_count), .cmd_gap(cmd_gap), .abort(abort),
    .photonFirstHalf(photonFirstHalf), .photonSecondHalf(photonSecondHalf),
    .photon2x(photon2x), .photon4x(photon4x), .exp_data(exp_data),
    .exp_valid(exp_valid), .busy(busy), .done(done), .pulse_cnt(pulse_cnt));

  typedef struct { int slot; int val; } ev_t;
  ev_t pq[$];
  ev_t eq[$];
  ev_t dq[$];

  int  edge_n = 0, free_slot = 0, b_start = 0, b_n = 0, b_gap = 0;
  bit  accepted = 1'b0;
  bit  mon_en = 1'b0;
  int  checks = 0, errors = 0;

  // Behavioural binner: registers the photon's eighth of the cycle as a one-hot byte.
  always_ff @(posedge clkin) begin
    if (!rstn) bin_data <= 8'd0;
    else if (photonFirstHalf || photonSecondHalf)
      bin_data <= 8'd1 << {photonSecondHalf, ~photon2x, ~photon4x};
    else bin_data <= 8'd0;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s slot %0d: got %0d expected %0d", name, edge_n, act, req);
    end
  endtask

  function automatic int exp_cnt(input int s);
    int k;
    if (s <= b_start) return 0;
    k = (s - 1 - b_start) / (b_gap + 1) + 1;
    return (k < b_n) ? k : b_n;
  endfunction

  // Applies the inputs sampled at edge edge_n (driven during slot edge_n-1).
  task automatic model_edge();
    int k, p, d, lines;
    accepted = 1'b0;
    if (!rstn) begin
      pq.delete(); eq.delete(); dq.delete();
      free_slot = edge_n; b_start = edge_n; b_n = 0; b_gap = 0;
    end else if (abort && ((edge_n - 1) < free_slot)) begin
      while (pq.size() > 0 && pq[$].slot > edge_n - 1) void'(pq.pop_back());
      while (eq.size() > 0 && eq[$].slot > edge_n) void'(eq.pop_back());
      dq.delete();
      k = (edge_n - 1 - b_start) / (b_gap + 1) + 1;
      if (k < b_n) b_n = k;
      free_slot = edge_n;
    end else if (cmd_valid && ((edge_n - 1) >= free_slot)) begin
      accepted = 1'b1;
      b_start = edge_n; b_n = int'(cmd_count); b_gap = int'(cmd_gap);
      lines = int'({~cmd_bin[2], cmd_bin[2], ~cmd_bin[1], ~cmd_bin[0]});
      for (int i = 0; i < b_n; i++) begin
        p = edge_n + i * (b_gap + 1);
        pq.push_back('{p, lines});
        eq.push_back('{p + 1, 1 << cmd_bin});
      end
      d = (b_n == 0) ? edge_n : edge_n + (b_n - 1) * (b_gap + 1) + 1;
      dq.push_back('{d, b_n});
      free_slot = d;
    end
  endtask

  task automatic step();
    @(posedge clkin);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic send(input int b, input int c, input int g);
    int n;
    cmd_bin = 3'(b); cmd_count = CW'(c); cmd_gap = GW'(g); cmd_valid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!accepted && n < 70000);
    if (!accepted) check("accept_timeout", 0, 1);
    cmd_valid = 1'b0;
    cmd_bin = 3'($urandom); cmd_count = CW'($urandom); cmd_gap = GW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (edge_n < free_slot && n < 70000) begin step(); n++; end
    if (edge_n < free_slot) check("idle_timeout", 0, 1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT is due to present an output.
  always @(negedge clkin) begin
    if (mon_en) begin
      int s;
      s = edge_n;
      if (pq.size() > 0 && pq[0].slot == s) begin
        check("pulse_lines", {photonFirstHalf, photonSecondHalf, photon2x, photon4x}, pq[0].val);
        void'(pq.pop_front());
      end else check("idle_lines", {photonFirstHalf, photonSecondHalf, photon2x, photon4x}, 0);
      if (eq.size() > 0 && eq[0].slot == s) begin
        check("exp_valid_hi", exp_valid, 1);
        check("exp_data", exp_data, eq[0].val);
        void'(eq.pop_front());
      end else begin
        check("exp_valid_lo", exp_valid, 0);
        check("exp_data_zero", exp_data, 0);
      end
      if (dq.size() > 0 && dq[0].slot == s) begin
        check("done_hi", done, 1);
        check("done_pulse_cnt", pulse_cnt, dq[0].val);
        void'(dq.pop_front());
      end else check("done_lo", done, 0);
      check("cmd_ready", cmd_ready, (s >= free_slot) ? 1 : 0);
      check("busy", busy, (s >= free_slot) ? 0 : 1);
      check("pulse_cnt", pulse_cnt, exp_cnt(s));
      check("binner_vs_exp", bin_data, exp_data);
      check("halves_exclusive", photonFirstHalf & photonSecondHalf, 0);
    end
  end

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_bin = 3'd0; cmd_count = '0; cmd_gap = '0;
    repeat (3) step();
    rstn = 1'b1;
    step();
    mon_en = 1'b1;
    repeat (5) step();

    send(0, 1, 0); wait_idle(); step();
    for (int b = 0; b < 8; b++) begin send(b, 1, 0); wait_idle(); step(); end
    send(5, 4, 2); wait_idle(); step();

    // Abort sampled at the edge closing the third back-to-back pulse.
    send(3, 10, 0);
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    repeat (3) step();

    send(2, 0, 0); wait_idle(); step();

    // Valid held across a burst: the second command waits for the done cycle.
    send(2, 3, 1);
    send(6, 2, 0);
    send(0, 0, 0);
    send(7, 1, 3);
    wait_idle(); step();

    // Abort together with a command in idle: the command is accepted.
    abort = 1'b1;
    send(4, 2, 0);
    abort = 1'b0;
    wait_idle(); step();

    // Reset in the middle of a gapped burst.
    send(6, 5, 1);
    repeat (2) step();
    rstn = 1'b0; step(); rstn = 1'b1;
    repeat (3) step();

    for (int it = 0; it < 40; it++) begin
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 5)) step();
        abort = 1'b1; step(); abort = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) begin wait_idle(); repeat ($urandom_range(0, 2)) step(); end
    end
    wait_idle(); step();

    // Full-width repeat count.
    send(1, 65535, 0); wait_idle();
    repeat (4) step();

    check("pulse_queue_drained", pq.size(), 0);
    check("exp_queue_drained", eq.size(), 0);
    check("done_queue_drained", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
